// File: rtl/ext_pkg.sv
// Shared types and field positions for the registered immediate extender.
package ext_pkg;

    // Extension modes selected by the decoder.
    typedef enum logic [2:0] {
        EXT_ZE5   = 3'd0,
        EXT_SE15  = 3'd1,
        EXT_ZE15  = 3'd2,
        EXT_SE20  = 3'd3,
        EXT_BR24  = 3'd4,
        EXT_SE15H = 3'd5,
        EXT_SE15W = 3'd6,
        EXT_RSVD  = 3'd7
    } ext_mode_e;

    // Occupancy of the main/skid storage pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ext_state_e;

    // Immediate field positions inside the raw instruction bits.
    localparam int ZE5_LSB = 10;
    localparam int ZE5_MSB = 14;
    localparam int F15_MSB = 14;
    localparam int F20_MSB = 19;
    localparam int F24_MSB = 23;

endpackage

// File: rtl/ext_format.sv
// Combinational immediate formatter: (instr, mode) -> (imm, illegal).
// Modes 5/6 (scaled) are only built when EXT_SCALE_EN is defined; otherwise
// they report illegal with a zero immediate, like the reserved mode.
module ext_format
    import ext_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int IW    = 24
) (
    input  logic [IW-1:0]    instr,
    input  logic [2:0]       mode,
    output logic [DSIZE-1:0] imm,
    output logic             illegal
);

    logic [DSIZE-1:0] ze5_s;
    logic [DSIZE-1:0] se15_s;
    logic [DSIZE-1:0] ze15_s;
    logic [DSIZE-1:0] se20_s;
    logic [DSIZE-1:0] br24_s;

    assign ze5_s  = {{(DSIZE-5){1'b0}}, instr[ZE5_MSB:ZE5_LSB]};
    assign se15_s = {{(DSIZE-15){instr[F15_MSB]}}, instr[F15_MSB:0]};
    assign ze15_s = {{(DSIZE-15){1'b0}}, instr[F15_MSB:0]};
    assign se20_s = {{(DSIZE-20){instr[F20_MSB]}}, instr[F20_MSB:0]};
    // Branch offsets are halfword-scaled: append one zero below the sign-extended field.
    assign br24_s = {{(DSIZE-25){instr[F24_MSB]}}, instr[F24_MSB:0], 1'b0};

`ifdef EXT_SCALE_EN
    logic [DSIZE-1:0] se15h_s;
    logic [DSIZE-1:0] se15w_s;

    assign se15h_s = {{(DSIZE-16){instr[F15_MSB]}}, instr[F15_MSB:0], 1'b0};
    assign se15w_s = {{(DSIZE-17){instr[F15_MSB]}}, instr[F15_MSB:0], 2'b00};
`endif

    // Select the formatted field for the requested mode; unknown modes are illegal.
    always_comb begin
        imm     = {DSIZE{1'b0}};
        illegal = 1'b0;
        case (ext_mode_e'(mode))
            EXT_ZE5:   imm = ze5_s;
            EXT_SE15:  imm = se15_s;
            EXT_ZE15:  imm = ze15_s;
            EXT_SE20:  imm = se20_s;
            EXT_BR24:  imm = br24_s;
`ifdef EXT_SCALE_EN
            EXT_SE15H: imm = se15h_s;
            EXT_SE15W: imm = se15w_s;
`endif
            default: begin
                imm     = {DSIZE{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate extender with a 2-entry skid buffer between decode
// and execute. in_ready comes straight from a flop, so no combinational
// path runs from out_ready to in_ready. Optional scaled modes: EXT_SCALE_EN.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int IW    = 24,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_instr,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [DSIZE-1:0] fmt_imm_s;
    logic             fmt_ill_s;
    logic             accept_s;
    logic             drain_s;

    ext_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [DSIZE-1:0] main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_ill_q, main_ill_d;
    logic [DSIZE-1:0] skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;

    // Formatting happens before storage so both registers hold final results.
    ext_format #(
        .DSIZE (DSIZE),
        .IW    (IW)
    ) u_format (
        .instr   (in_instr),
        .mode    (in_mode),
        .imm     (fmt_imm_s),
        .illegal (fmt_ill_s)
    );

    assign accept_s = in_valid & in_ready_q;
    assign drain_s  = out_valid_q & out_ready;

    // Next-state and storage steering: skid always refills main before new input.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        main_imm_d = fmt_imm_s;
                        main_tag_d = in_tag;
                        main_ill_d = fmt_ill_s;
                        state_d    = ONE;
                    end else begin
                        state_d    = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && drain_s) begin
                        main_imm_d = fmt_imm_s;
                        main_tag_d = in_tag;
                        main_ill_d = fmt_ill_s;
                        state_d    = ONE;
                    end else if (accept_s) begin
                        skid_imm_d = fmt_imm_s;
                        skid_tag_d = in_tag;
                        skid_ill_d = fmt_ill_s;
                        state_d    = FULL;
                    end else if (drain_s) begin
                        state_d    = EMPTY;
                    end else begin
                        state_d    = ONE;
                    end
                end
                FULL: begin
                    if (drain_s) begin
                        main_imm_d = skid_imm_q;
                        main_tag_d = skid_tag_q;
                        main_ill_d = skid_ill_q;
                        state_d    = ONE;
                    end else begin
                        state_d    = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_imm_q  <= {DSIZE{1'b0}};
            main_tag_q  <= {TAG_W{1'b0}};
            main_ill_q  <= 1'b0;
            skid_imm_q  <= {DSIZE{1'b0}};
            skid_tag_q  <= {TAG_W{1'b0}};
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            main_imm_q  <= main_imm_d;
            main_tag_q  <= main_tag_d;
            main_ill_q  <= main_ill_d;
            skid_imm_q  <= skid_imm_d;
            skid_tag_q  <= skid_tag_d;
            skid_ill_q  <= skid_ill_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = main_imm_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe (DSIZE=32). A FIFO-of-entries model with
// arithmetic immediate formatting predicts every output.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic [2:0]  in_mode;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [7:0]  out_tag;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        longint imm;
        int     tag;
        bit     ill;
    } ent_t;

    ent_t q[$];
    bit   rst_edge;

    ext_pipe #(.DSIZE(32), .IW(24), .TAG_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_mode     (in_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        if (v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
        else return v;
    endfunction

    function automatic ent_t ref_fmt(input int m, input longint ins, input int tg);
        ent_t e;
        e.tag = tg;
        e.ill = 1'b0;
        case (m)
            0: e.imm = (ins >> 10) & 31;
            1: e.imm = sx(ins & 'h7FFF, 15);
            2: e.imm = ins & 'h7FFF;
            3: e.imm = sx(ins & 'hFFFFF, 20);
            4: e.imm = sx(ins & 'hFFFFFF, 24) * 2;
`ifdef EXT_SCALE_EN
            5: e.imm = sx(ins & 'h7FFF, 15) * 2;
            6: e.imm = sx(ins & 'h7FFF, 15) * 4;
`endif
            default: begin
                e.imm = 0;
                e.ill = 1'b1;
            end
        endcase
        e.imm = e.imm & 'hFFFFFFFF;
        return e;
    endfunction

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic cycle(input logic v, input logic [2:0] m, input logic [23:0] ins,
                         input logic [7:0] tg, input logic ordy, input logic fl, input logic rs);
        bit can_acc;
        in_valid  = v;
        in_mode   = m;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        rst_edge = !rs;
        if (!rs) begin
            q.delete();
        end else if (fl) begin
            q.delete();
        end else begin
            can_acc = (q.size() < 2);
            if (ordy && q.size() > 0) void'(q.pop_front());
            if (v && can_acc) q.push_back(ref_fmt(int'(m), longint'(ins), int'(tg)));
        end
        @(negedge clk);
        check_val("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check_val("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            check_val("out_imm", 64'(out_imm), 64'(q[0].imm));
            check_val("out_tag", 64'(out_tag), 64'(q[0].tag));
            check_val("out_illegal", 64'(out_illegal), 64'(q[0].ill));
        end
        if (rst_edge) begin
            check_val("rst_imm", 64'(out_imm), 64'd0);
            check_val("rst_tag", 64'(out_tag), 64'd0);
            check_val("rst_ill", 64'(out_illegal), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 24'd0;
        in_mode = 3'd0; in_tag = 8'd0; out_ready = 1'b0;
        @(negedge clk);
        cycle(1'b0, 3'd0, 24'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 24'd0, 8'd0, 1'b0, 1'b0, 1'b1);

        // Directed format cases.
        cycle(1'b1, 3'd1, 24'h004000, 8'h10, 1'b1, 1'b0, 1'b1);
        check_val("se15", 64'(out_imm), 64'h0000_0000_FFFF_C000);
        cycle(1'b1, 3'd2, 24'h004000, 8'h11, 1'b1, 1'b0, 1'b1);
        check_val("ze15", 64'(out_imm), 64'h0000_4000);
        cycle(1'b1, 3'd0, 24'h007C00, 8'h12, 1'b1, 1'b0, 1'b1);
        check_val("ze5", 64'(out_imm), 64'h0000_001F);
        cycle(1'b1, 3'd4, 24'h800001, 8'h13, 1'b1, 1'b0, 1'b1);
        check_val("br24", 64'(out_imm), 64'h0000_0000_FF00_0002);
        cycle(1'b1, 3'd7, 24'hFFFFFF, 8'h14, 1'b1, 1'b0, 1'b1);
        check_val("rsvd_imm", 64'(out_imm), 64'd0);
        check_val("rsvd_ill", 64'(out_illegal), 64'd1);
        cycle(1'b1, 3'd6, 24'h000003, 8'h15, 1'b1, 1'b0, 1'b1);
`ifdef EXT_SCALE_EN
        check_val("se15w", 64'(out_imm), 64'h0000_000C);
        check_val("se15w_ill", 64'(out_illegal), 64'd0);
`else
        check_val("se15w_off", 64'(out_imm), 64'd0);
        check_val("se15w_off_ill", 64'(out_illegal), 64'd1);
`endif
        cycle(1'b0, 3'd0, 24'd0, 8'd0, 1'b1, 1'b0, 1'b1);

        // Backpressure: three inputs with out_ready low, then drain in order.
        cycle(1'b1, 3'd2, 24'h000101, 8'd1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd2, 24'h000102, 8'd2, 1'b0, 1'b0, 1'b1);
        check_val("bp_full_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 3'd2, 24'h000103, 8'd3, 1'b0, 1'b0, 1'b1);
        check_val("bp_hold_tag", 64'(out_tag), 64'd1);
        cycle(1'b1, 3'd2, 24'h000103, 8'd3, 1'b1, 1'b0, 1'b1);
        check_val("bp_tag2", 64'(out_tag), 64'd2);
        cycle(1'b1, 3'd2, 24'h000103, 8'd3, 1'b1, 1'b0, 1'b1);
        check_val("bp_tag3", 64'(out_tag), 64'd3);
        cycle(1'b0, 3'd0, 24'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        check_val("bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a simultaneous input that must be dropped.
        cycle(1'b1, 3'd1, 24'h000201, 8'd21, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd1, 24'h000202, 8'd22, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd1, 24'h000203, 8'd23, 1'b0, 1'b1, 1'b1);
        check_val("flush_valid", 64'(out_valid), 64'd0);
        check_val("flush_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, 3'd0, 24'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        check_val("flush_no_ghost", 64'(out_valid), 64'd0);

        // Reset while FULL.
        cycle(1'b1, 3'd3, 24'h0F0001, 8'd31, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd3, 24'h0F0002, 8'd32, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd3, 24'h0F0003, 8'd33, 1'b1, 1'b1, 1'b0);
        check_val("mrst_valid", 64'(out_valid), 64'd0);
        check_val("mrst_imm", 64'(out_imm), 64'd0);
        check_val("mrst_tag", 64'(out_tag), 64'd0);
        cycle(1'b0, 3'd0, 24'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        check_val("mrst_ready", 64'(in_ready), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 7),
                  3'($urandom_range(0, 7)),
                  24'($urandom),
                  8'($urandom),
                  1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 99) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
